// File: rtl/fpu8_exception_responder.sv
// Exception responder for the 8-bit FPU (1/4/3 format, bias 7).
// Classifies both operands and produces the special result plus sticky flags.
module fpu8_exception_responder #(
  parameter logic [7:0] NAN_CODE = 8'h7C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_special,
  output logic [7:0] res_data,
  output logic       flag_invalid,
  output logic       flag_divzero,
  input  logic       clr_flags
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLASSIFY = 2'd1,
    RESOLVE  = 2'd2,
    RESPOND  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_ZERO   = 2'd0,
    CLS_FINITE = 2'd1,
    CLS_INF    = 2'd2,
    CLS_NAN    = 2'd3
  } cls_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;
  localparam logic [6:0] INF_MAG = 7'h78;

  function automatic cls_t classify(input logic [7:0] v);
    cls_t c;
    if (v[6:3] == 4'hF) begin
      c = (v[2:0] == 3'd0) ? CLS_INF : CLS_NAN;
    end else if (v[6:0] == 7'd0) begin
      c = CLS_ZERO;
    end else begin
      c = CLS_FINITE;
    end
    return c;
  endfunction

  state_t     state_r, state_nxt_s;
  logic [1:0] op_r;
  logic [7:0] a_r, b_r;
  cls_t       cls_a_r, cls_b_r;
  logic       req_ready_r, res_valid_r, res_special_r;
  logic [7:0] res_data_r;
  logic       flag_inv_r, flag_dz_r;

  logic       rsv_special_s, rsv_inv_s, rsv_dz_s;
  logic [7:0] rsv_data_s;
  logic       sign_x_s;
  logic       na_s, nb_s, ia_s, ib_s, za_s, zb_s, fa_s;

  assign req_ready    = req_ready_r;
  assign res_valid    = res_valid_r;
  assign res_special  = res_special_r;
  assign res_data     = res_data_r;
  assign flag_invalid = flag_inv_r;
  assign flag_divzero = flag_dz_r;

  assign sign_x_s = a_r[7] ^ b_r[7];
  assign na_s = (cls_a_r == CLS_NAN);
  assign nb_s = (cls_b_r == CLS_NAN);
  assign ia_s = (cls_a_r == CLS_INF);
  assign ib_s = (cls_b_r == CLS_INF);
  assign za_s = (cls_a_r == CLS_ZERO);
  assign zb_s = (cls_b_r == CLS_ZERO);
  assign fa_s = (cls_a_r == CLS_FINITE);

  // Next-state decode of the request/response sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid && req_ready_r) begin
          state_nxt_s = CLASSIFY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CLASSIFY: state_nxt_s = RESOLVE;
      RESOLVE:  state_nxt_s = RESPOND;
      RESPOND: begin
        if (res_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESPOND;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Special-result priority resolution; B's sign is already flipped for sub.
  always_comb begin
    rsv_special_s = 1'b0;
    rsv_data_s    = 8'h00;
    rsv_inv_s     = 1'b0;
    rsv_dz_s      = 1'b0;
    if (na_s || nb_s) begin
      rsv_special_s = 1'b1;
      rsv_data_s    = NAN_CODE;
    end else begin
      case (op_r)
        OP_ADD, OP_SUB: begin
          if (ia_s && ib_s && (a_r[7] != b_r[7])) begin
            rsv_special_s = 1'b1;
            rsv_data_s    = NAN_CODE;
            rsv_inv_s     = 1'b1;
          end else if (ia_s) begin
            rsv_special_s = 1'b1;
            rsv_data_s    = {a_r[7], INF_MAG};
          end else if (ib_s) begin
            rsv_special_s = 1'b1;
            rsv_data_s    = {b_r[7], INF_MAG};
          end else begin
            rsv_special_s = 1'b0;
          end
        end
        OP_MUL: begin
          if ((ia_s && zb_s) || (za_s && ib_s)) begin
            rsv_special_s = 1'b1;
            rsv_data_s    = NAN_CODE;
            rsv_inv_s     = 1'b1;
          end else if (ia_s || ib_s) begin
            rsv_special_s = 1'b1;
            rsv_data_s    = {sign_x_s, INF_MAG};
          end else begin
            rsv_special_s = 1'b0;
          end
        end
        OP_DIV: begin
          if ((za_s && zb_s) || (ia_s && ib_s)) begin
            rsv_special_s = 1'b1;
            rsv_data_s    = NAN_CODE;
            rsv_inv_s     = 1'b1;
          end else if (fa_s && zb_s) begin
            rsv_special_s = 1'b1;
            rsv_data_s    = {sign_x_s, INF_MAG};
            rsv_dz_s      = 1'b1;
          end else if (ia_s) begin
            rsv_special_s = 1'b1;
            rsv_data_s    = {sign_x_s, INF_MAG};
          end else if (ib_s) begin
            rsv_special_s = 1'b1;
            rsv_data_s    = {sign_x_s, 7'h00};
          end else begin
            rsv_special_s = 1'b0;
          end
        end
        default: rsv_special_s = 1'b0;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture, classification and registered handshake/result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r          <= 2'b00;
      a_r           <= 8'h00;
      b_r           <= 8'h00;
      cls_a_r       <= CLS_ZERO;
      cls_b_r       <= CLS_ZERO;
      req_ready_r   <= 1'b1;
      res_valid_r   <= 1'b0;
      res_special_r <= 1'b0;
      res_data_r    <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready_r) begin
            op_r        <= req_op;
            a_r         <= req_a;
            b_r         <= req_b;
            req_ready_r <= 1'b0;
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        CLASSIFY: begin
          cls_a_r <= classify(a_r);
          cls_b_r <= classify(b_r);
          if (op_r == OP_SUB) begin
            b_r <= b_r ^ 8'h80;
          end
        end
        RESOLVE: begin
          res_special_r <= rsv_special_s;
          res_data_r    <= rsv_data_s;
          res_valid_r   <= 1'b1;
        end
        RESPOND: begin
          if (res_ready) begin
            res_valid_r   <= 1'b0;
            res_special_r <= 1'b0;
            res_data_r    <= 8'h00;
          end
        end
        default: req_ready_r <= 1'b0;
      endcase
    end
  end

  // Sticky flags: a set pulse on the RESOLVE edge beats a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_inv_r <= 1'b0;
      flag_dz_r  <= 1'b0;
    end else begin
      flag_inv_r <= ((state_r == RESOLVE) && rsv_inv_s) || (flag_inv_r && !clr_flags);
      flag_dz_r  <= ((state_r == RESOLVE) && rsv_dz_s) || (flag_dz_r && !clr_flags);
    end
  end

endmodule

// File: tb/tb_fpu8_exception_responder.sv
// Self-checking bench for fpu8_exception_responder: directed table,
// multi-cycle corner sequences and randomized requests against a reference model.
module tb_fpu8_exception_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready;
  logic [1:0] req_op;
  logic [7:0] req_a, req_b;
  logic       res_valid, res_ready, res_special;
  logic [7:0] res_data;
  logic       flag_invalid, flag_divzero, clr_flags;

  int n_cmp = 0;
  int n_bad = 0;
  logic m_inv, m_dz;

  fpu8_exception_responder dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_special(res_special), .res_data(res_data),
    .flag_invalid(flag_invalid), .flag_divzero(flag_divzero),
    .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       sp;
    logic [7:0] d;
    logic       inv;
    logic       dz;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns {special, invalid, divzero, data[7:0]} from the IEEE-style rules.
  function automatic logic [10:0] ref_model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] bb;
    bit za, zb, ia, ib, na, nb, fa;
    logic s;
    bb = (op == 2'b01) ? (b ^ 8'h80) : b;
    za = (a[6:0] == 7'd0);
    zb = (bb[6:0] == 7'd0);
    ia = (a[6:0] == 7'h78);
    ib = (bb[6:0] == 7'h78);
    na = (a[6:3] == 4'hF) && !ia;
    nb = (bb[6:3] == 4'hF) && !ib;
    fa = !za && !ia && !na;
    s  = a[7] ^ bb[7];
    if (na || nb) return {3'b100, 8'h7C};
    if (op[1] == 1'b0) begin
      if (ia && ib && (a[7] != bb[7])) return {3'b110, 8'h7C};
      if (ia) return {3'b100, a};
      if (ib) return {3'b100, bb};
      return 11'd0;
    end
    if (op == 2'b10) begin
      if ((ia && zb) || (za && ib)) return {3'b110, 8'h7C};
      if (ia || ib) return {3'b100, s, 7'h78};
      return 11'd0;
    end
    if ((za && zb) || (ia && ib)) return {3'b110, 8'h7C};
    if (fa && zb) return {3'b101, s, 7'h78};
    if (ia) return {3'b100, s, 7'h78};
    if (ib) return {3'b100, s, 7'h00};
    return 11'd0;
  endfunction

  task automatic clear_flags();
    clr_flags = 1'b1;
    @(posedge clk); #1;
    clr_flags = 1'b0;
    m_inv = 1'b0;
    m_dz  = 1'b0;
    check("clr_invalid", flag_invalid, 0);
    check("clr_divzero", flag_divzero, 0);
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input int stall, input bit clr_at_set,
                       input logic exp_sp, input logic [7:0] exp_d,
                       input logic exp_inv, input logic exp_dz);
    int w;
    int lat;
    w = 0;
    while (!req_ready && w < 8) begin
      @(posedge clk); #1;
      w++;
    end
    check("req_ready_idle", req_ready, 1);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = 2'($urandom); req_a = 8'($urandom); req_b = 8'($urandom);
    lat = 1;
    while (!res_valid && lat < 8) begin
      check("busy_ready", req_ready, 0);
      if (lat == 2 && clr_at_set) clr_flags = 1'b1;
      @(posedge clk); #1;
      clr_flags = 1'b0;
      lat++;
    end
    check("latency", lat, 3);
    check("res_special", res_special, exp_sp);
    check("res_data", res_data, exp_d);
    check("flag_invalid", flag_invalid, exp_inv);
    check("flag_divzero", flag_divzero, exp_dz);
    check("ready_in_respond", req_ready, 0);
    for (int i = 0; i < stall; i++) begin
      res_ready = 1'b0;
      @(posedge clk); #1;
      check("stall_valid", res_valid, 1);
      check("stall_special", res_special, exp_sp);
      check("stall_data", res_data, exp_d);
      check("stall_ready", req_ready, 0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("valid_drop", res_valid, 0);
    check("ready_low_on_drop", req_ready, 0);
    @(posedge clk); #1;
    check("ready_return", req_ready, 1);
  endtask

  initial begin
    logic [7:0] pool[10];
    logic [10:0] r;
    logic [1:0] op;
    logic [7:0] a, b;
    bit cs;

    pool = '{8'h00, 8'h80, 8'h78, 8'hF8, 8'h7C, 8'hFF, 8'h38, 8'hC0, 8'h01, 8'h81};
    tbl[0]  = '{2'b00, 8'h78, 8'hF8, 1'b1, 8'h7C, 1'b1, 1'b0};
    tbl[1]  = '{2'b01, 8'h78, 8'h78, 1'b1, 8'h7C, 1'b1, 1'b0};
    tbl[2]  = '{2'b01, 8'h78, 8'h00, 1'b1, 8'h78, 1'b0, 1'b0};
    tbl[3]  = '{2'b11, 8'hB8, 8'h00, 1'b1, 8'hF8, 1'b0, 1'b1};
    tbl[4]  = '{2'b10, 8'h00, 8'hF8, 1'b1, 8'h7C, 1'b1, 1'b0};
    tbl[5]  = '{2'b00, 8'h38, 8'h40, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[6]  = '{2'b11, 8'h7C, 8'h00, 1'b1, 8'h7C, 1'b0, 1'b0};
    tbl[7]  = '{2'b10, 8'hF8, 8'hC0, 1'b1, 8'h78, 1'b0, 1'b0};
    tbl[8]  = '{2'b11, 8'h00, 8'h00, 1'b1, 8'h7C, 1'b1, 1'b0};
    tbl[9]  = '{2'b11, 8'hF8, 8'hF8, 1'b1, 8'h7C, 1'b1, 1'b0};
    tbl[10] = '{2'b11, 8'h78, 8'h80, 1'b1, 8'hF8, 1'b0, 1'b0};
    tbl[11] = '{2'b11, 8'h40, 8'hF8, 1'b1, 8'h80, 1'b0, 1'b0};
    tbl[12] = '{2'b01, 8'h38, 8'hF8, 1'b1, 8'h78, 1'b0, 1'b0};
    tbl[13] = '{2'b00, 8'h01, 8'hFF, 1'b1, 8'h7C, 1'b0, 1'b0};
    tbl[14] = '{2'b10, 8'h38, 8'h40, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[15] = '{2'b00, 8'h78, 8'h78, 1'b1, 8'h78, 1'b0, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_a = 8'h00; req_b = 8'h00;
    res_ready = 1'b0; clr_flags = 1'b0; m_inv = 1'b0; m_dz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_special", res_special, 0);
    check("rst_res_data", res_data, 0);
    check("rst_flag_invalid", flag_invalid, 0);
    check("rst_flag_divzero", flag_divzero, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      clear_flags();
      issue(tbl[i].op, tbl[i].a, tbl[i].b, 0, 1'b0, tbl[i].sp, tbl[i].d, tbl[i].inv, tbl[i].dz);
    end
    clear_flags();

    // Set beats clear on the same edge; a bare clear on that edge still clears.
    issue(2'b10, 8'h00, 8'hF8, 0, 1'b0, 1'b1, 8'h7C, 1'b1, 1'b0);
    issue(2'b10, 8'h00, 8'hF8, 0, 1'b1, 1'b1, 8'h7C, 1'b1, 1'b0);
    issue(2'b00, 8'h38, 8'h40, 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    issue(2'b00, 8'h38, 8'h40, 5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    issue(2'b11, 8'hB8, 8'h00, 0, 1'b0, 1'b1, 8'hF8, 1'b0, 1'b1);

    // Reset during RESOLVE drops the request.
    req_op = 2'b11; req_a = 8'h7C; req_b = 8'h00; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_valid", res_valid, 0);
    check("midrst_ready", req_ready, 1);
    check("midrst_invalid", flag_invalid, 0);
    check("midrst_divzero", flag_divzero, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_inv = 1'b0; m_dz = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("midrst_no_result", res_valid, 0);
    end
    check("midrst_ready_after", req_ready, 1);
    issue(2'b11, 8'h7C, 8'h00, 0, 1'b0, 1'b1, 8'h7C, 1'b0, 1'b0);

    for (int i = 0; i < 250; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 9)] : 8'($urandom);
      b  = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 9)] : 8'($urandom);
      cs = ($urandom_range(0, 7) == 0);
      r  = ref_model(op, a, b);
      if (cs) begin
        m_inv = r[9];
        m_dz  = r[8];
      end else begin
        m_inv = m_inv | r[9];
        m_dz  = m_dz | r[8];
      end
      issue(op, a, b, $urandom_range(0, 2), cs, r[10], r[7:0], m_inv, m_dz);
      if ($urandom_range(0, 9) == 0) clear_flags();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fpu8_exception_responder.md
Name: fpu8_exception_responder

Overview:
- Sequential responder that sits behind the FPU_8 exception detector. It accepts one operation request (opcode plus two 8-bit operands) per handshake and classifies both operands.
- It produces the IEEE-style special result (NaN, ±Inf or ±0) that the datapath must substitute, and keeps sticky status flags for software.
- It sits between the issue stage and the result mux: when res_special=1 the mux takes res_data in place of the arithmetic unit output.

Parameters:
- NAN_CODE, 8'h7C, canonical quiet NaN driven for every invalid or NaN-propagating case.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_op  in  2  opcode: 00 add, 01 sub, 10 mul, 11 div
- req_a  in  8  operand A, format 1 sign / 4 exponent / 3 mantissa, bias 7
- req_b  in  8  operand B, same format
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- res_special  out  1  1 = res_data replaces the datapath result
- res_data  out  8  special result (8'h00 when res_special=0)
- flag_invalid  out  1  sticky invalid-operation flag
- flag_divzero  out  1  sticky divide-by-zero flag
- clr_flags  in  1  synchronous clear of both sticky flags

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: state=IDLE, req_ready=1, res_valid=0, res_special=0, res_data=8'h00, both flags=0.
- Operand classes (exp=bits[6:3], man=bits[2:0]):
  - ZERO: exp=0 and man=0.
  - INF: exp=F and man=0.
  - NAN: exp=F and man≠0.
  - FINITE: everything else, including denormals.
- FSM states: IDLE → CLASSIFY → RESOLVE → RESPOND → IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, register op, a and b, then go to CLASSIFY.
- CLASSIFY (1 cycle):
  - Register the class of each operand.
  - For sub, flip B's sign bit here; sub is then treated as add.
- RESOLVE (1 cycle): compute res_special, res_data and flag set-pulses using the priority order below. The first rule that matches wins.
  - 1. Either operand NAN → NAN_CODE, special=1, no flag.
  - 2. add with INF+INF of opposite sign → NAN_CODE, invalid.
  - 3. add with any INF → that INF (sign from the INF operand).
  - 4. mul with INF×ZERO (either order) → NAN_CODE, invalid.
  - 5. mul with any INF → INF, sign = sa^sb.
  - 6. div with ZERO/ZERO or INF/INF → NAN_CODE, invalid.
  - 7. div with FINITE/ZERO → INF, sign = sa^sb, divzero.
  - 8. div with INF/(FINITE or ZERO) → INF, sign = sa^sb.
  - 9. div with (FINITE or ZERO)/INF → ZERO, sign = sa^sb (8'h00 or 8'h80).
  - 10. Otherwise → special=0, res_data=8'h00.
- Latency: the request handshake in cycle N gives res_valid=1 in cycle N+3 (after CLASSIFY, RESOLVE and the RESPOND entry edge). In RESOLVE, go to RESPOND.
- RESPOND:
  - res_valid=1.
  - res_special and res_data stay stable until res_valid&res_ready.
  - On that handshake edge, go to IDLE and set res_valid=0. No back-to-back bypass: req_ready is low in the cycle res_valid drops, and returns high the next cycle.
- req_ready=0 in CLASSIFY, RESOLVE and RESPOND. req_valid is ignored there.
- Sticky flags:
  - A flag sets on the RESOLVE→RESPOND edge when its rule fires.
  - The flag holds until clr_flags.
  - If clr_flags and a set-pulse land on the same edge, the set wins (flag=1).
  - clr_flags has no effect on the FSM.
- Reset mid-operation: from any state, go straight to the reset values. The pending request is dropped and no result is emitted.
- Stall: res_ready held low indefinitely keeps RESPOND with all outputs unchanged.

Test Plan:
- add, a=8'h78 (+Inf), b=8'hF8 (−Inf), res_ready=1 → res_valid 3 cycles after the handshake; res_special=1, res_data=8'h7C, flag_invalid=1, flag_divzero=0.
- sub, a=8'h78, b=8'h78 → B flipped, so this is Inf−Inf: res_data=8'h7C, flag_invalid=1. Also sub, a=8'h78, b=8'h00 → res_data=8'h78, flags unchanged.
- div, a=8'hB8 (−1.0), b=8'h00 → res_data=8'hF8, flag_divzero=1. Then pulse clr_flags alone → both flags 0.
- mul, a=8'h00, b=8'hF8 → res_data=8'h7C, flag_invalid=1. Repeat with clr_flags asserted on the setting edge → flag_invalid stays 1.
- add, a=8'h38, b=8'h40 (ordinary finite operands) with res_ready held low 5 cycles → res_valid stays 1, res_special=0, res_data=8'h00 stable, req_ready=0 throughout; ready high → IDLE, and req_ready returns 1 the cycle after res_valid drops.
- div, a=8'h7C (NaN), b=8'h00, with rst asserted during RESOLVE → res_valid never rises, flags=0, req_ready=1 after reset. Reissue the request → res_data=8'h7C and flag_divzero stays 0 (NaN rule has priority).
